// File: rtl/branch_predict_unit.sv
// Branch predict unit: direct-mapped BTB with 2-bit counters; lookup, mispredict detection and training.
// Latency: lookup and flush/pc_branch are combinational; training lands at the next clk edge (read-before-write).
// Backpressure: none; stalls are invisible, each EX/MEM instruction arrives with ex_valid=1 exactly once.
// Optional macro BPU_PERF_CNT_EN adds perf_branches / perf_mispredicts counters.
module branch_predict_unit #(
  parameter int         INDEX_BITS = 4,
  parameter logic [1:0] CTR_INIT   = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        prediction,
  output logic [31:0] control_pc,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_is_branch,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
`ifdef BPU_PERF_CNT_EN
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispredicts,
`endif
  output logic        flush,
  output logic [31:0] pc_branch
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = 30 - INDEX_BITS;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];

  logic [INDEX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0]      if_tag, ex_tag;
  logic                  if_hit, ex_hit;

  // Instruction addresses are word aligned; the two low PC bits carry no information here.
  logic unused_lsbs;
  assign unused_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

  assign if_idx = if_pc[INDEX_BITS+1:2];
  assign if_tag = if_pc[31:INDEX_BITS+2];
  assign ex_idx = ex_pc[INDEX_BITS+1:2];
  assign ex_tag = ex_pc[31:INDEX_BITS+2];
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // Fetch-side lookup against the registered (pre-update) BTB contents.
  always_comb begin
    prediction = 1'b0;
    control_pc = if_pc + 32'd4;
    if (!rst && if_hit) begin
      prediction = ctr_q[if_idx][1];
      control_pc = target_q[if_idx];
    end
  end

  // Compare the resolved outcome against what was predicted and pick the corrected PC.
  always_comb begin
    flush     = 1'b0;
    pc_branch = 32'd0;
    if (!rst) begin
      pc_branch = (ex_is_branch && ex_taken) ? ex_target : (ex_pc + 32'd4);
      if (ex_valid) begin
        if (ex_is_branch)
          flush = (ex_taken != ex_pred_taken) ||
                  (ex_taken && (ex_pred_target != ex_target));
        else
          flush = ex_pred_taken;   // a non-branch was steered by an aliased entry
      end
    end
  end

  // Training: counter walk and target refresh on hits, allocate on taken misses, kill aliased entries.
  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (!rst && ex_valid) begin
      if (ex_is_branch) begin
        if (ex_hit) begin
          if (ex_taken) begin
            if (ctr_q[ex_idx] != 2'd3) ctr_d[ex_idx] = ctr_q[ex_idx] + 2'd1;
            target_d[ex_idx] = ex_target;
          end else if (ctr_q[ex_idx] != 2'd0) begin
            ctr_d[ex_idx] = ctr_q[ex_idx] - 2'd1;
          end
        end else if (ex_taken) begin
          valid_d[ex_idx]  = 1'b1;
          tag_d[ex_idx]    = ex_tag;
          target_d[ex_idx] = ex_target;
          ctr_d[ex_idx]    = CTR_INIT;
        end
      end else if (ex_hit) begin
        valid_d[ex_idx] = 1'b0;
      end
    end
  end

  // BTB state; reset only needs to clear valid bits and counters, tags/targets are don't-care.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b00;
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

`ifdef BPU_PERF_CNT_EN
  logic [31:0] perf_branches_q, perf_branches_d;
  logic [31:0] perf_mispredicts_q, perf_mispredicts_d;

  // Event counters; free-running modulo 2^32.
  always_comb begin
    perf_branches_d    = perf_branches_q + {31'd0, (ex_valid && ex_is_branch)};
    perf_mispredicts_d = perf_mispredicts_q + {31'd0, flush};
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches_q    <= 32'd0;
      perf_mispredicts_q <= 32'd0;
    end else begin
      perf_branches_q    <= perf_branches_d;
      perf_mispredicts_q <= perf_mispredicts_d;
    end
  end

  assign perf_branches    = perf_branches_q;
  assign perf_mispredicts = perf_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed-vector bench for branch_predict_unit with a decoupled expectation queue and monitor.
// Each vector is driven just after a clk edge; the monitor checks it on the following falling edge.
// Optional BPU_PERF_CNT_EN counter checks are compiled in only when the macro is defined.
module tb_branch_predict_unit;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        prediction;
  logic [31:0] control_pc;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_is_branch;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        flush;
  logic [31:0] pc_branch;
`ifdef BPU_PERF_CNT_EN
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;
`endif

  branch_predict_unit #(.INDEX_BITS(4), .CTR_INIT(2'b10)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .prediction     (prediction),
    .control_pc     (control_pc),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_is_branch   (ex_is_branch),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
`ifdef BPU_PERF_CNT_EN
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts),
`endif
    .flush          (flush),
    .pc_branch      (pc_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        pred;
    logic [31:0] cpc;
    logic        fl;
    logic [31:0] pcb;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Monitor: one expectation per cycle, checked mid-cycle while the driven inputs are stable.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_vec++;
      if (prediction !== e.pred) begin
        n_miss++;
        $display("FAIL %s prediction: got %0b want %0b", e.name, prediction, e.pred);
      end
      n_vec++;
      if (control_pc !== e.cpc) begin
        n_miss++;
        $display("FAIL %s control_pc: got %h want %h", e.name, control_pc, e.cpc);
      end
      n_vec++;
      if (flush !== e.fl) begin
        n_miss++;
        $display("FAIL %s flush: got %0b want %0b", e.name, flush, e.fl);
      end
      n_vec++;
      if (pc_branch !== e.pcb) begin
        n_miss++;
        $display("FAIL %s pc_branch: got %h want %h", e.name, pc_branch, e.pcb);
      end
    end
  end

  // Drive one cycle of inputs, queue its expected outputs, then advance past the clock edge.
  task automatic vec(input string name, input logic r, input logic [31:0] ipc,
                     input logic v, input logic [31:0] pc, input logic br, input logic tk,
                     input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                     input logic e_pred, input logic [31:0] e_cpc,
                     input logic e_fl, input logic [31:0] e_pcb);
    exp_t e;
    rst = r; if_pc = ipc; ex_valid = v; ex_pc = pc; ex_is_branch = br;
    ex_taken = tk; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    e.name = name; e.pred = e_pred; e.cpc = e_cpc; e.fl = e_fl; e.pcb = e_pcb;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Lookup-only cycle with EX/MEM holding a bubble (all ex_* zero, so pc_branch = 0+4).
  task automatic look(input string name, input logic [31:0] ipc,
                      input logic e_pred, input logic [31:0] e_cpc);
    vec(name, 1'b0, ipc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,
        e_pred, e_cpc, 1'b0, 32'h4);
  endtask

`ifdef BPU_PERF_CNT_EN
  task automatic chk_perf(input string name, input logic [31:0] e_br, input logic [31:0] e_mp);
    n_vec++;
    if (perf_branches !== e_br) begin
      n_miss++;
      $display("FAIL %s perf_branches: got %0d want %0d", name, perf_branches, e_br);
    end
    n_vec++;
    if (perf_mispredicts !== e_mp) begin
      n_miss++;
      $display("FAIL %s perf_mispredicts: got %0d want %0d", name, perf_mispredicts, e_mp);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; if_pc = 32'h0; ex_valid = 1'b0; ex_pc = 32'h0; ex_is_branch = 1'b0;
    ex_taken = 1'b0; ex_target = 32'h0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
    repeat (2) @(posedge clk);
    #1;

    //   name          rst   if_pc         v     ex_pc         br    tk    target        ptk   ptarget       pred  cpc           flush pc_branch
    vec("rst_hold",    1'b1, 32'h40,       1'b1, 32'h40,       1'b1, 1'b1, 32'h100,      1'b0, 32'h44,       1'b0, 32'h44,       1'b0, 32'h0);
    look("cold_look",  32'h40, 1'b0, 32'h44);
    vec("cold_alloc",  1'b0, 32'h40,       1'b1, 32'h40,       1'b1, 1'b1, 32'h100,      1'b0, 32'h44,       1'b0, 32'h44,       1'b1, 32'h100);
    look("alloc_vis",  32'h40, 1'b1, 32'h100);
    // counter 2 -> 1 -> 0; the not-taken branch with a stale ex_target must not flush
    vec("nt_1",        1'b0, 32'h40,       1'b1, 32'h40,       1'b1, 1'b0, 32'h100,      1'b1, 32'h100,      1'b1, 32'h100,      1'b1, 32'h44);
    vec("nt_2",        1'b0, 32'h40,       1'b1, 32'h40,       1'b1, 1'b0, 32'h500,      1'b0, 32'h100,      1'b0, 32'h100,      1'b0, 32'h44);
    look("ctr0",       32'h40, 1'b0, 32'h100);
    // counter 0 -> 1 -> 2 -> 3 -> 3
    vec("tk_1",        1'b0, 32'h40,       1'b1, 32'h40,       1'b1, 1'b1, 32'h100,      1'b0, 32'h100,      1'b0, 32'h100,      1'b1, 32'h100);
    vec("tk_2",        1'b0, 32'h40,       1'b1, 32'h40,       1'b1, 1'b1, 32'h100,      1'b0, 32'h100,      1'b0, 32'h100,      1'b1, 32'h100);
    vec("tk_3",        1'b0, 32'h40,       1'b1, 32'h40,       1'b1, 1'b1, 32'h100,      1'b1, 32'h100,      1'b1, 32'h100,      1'b0, 32'h100);
    vec("tk_4",        1'b0, 32'h40,       1'b1, 32'h40,       1'b1, 1'b1, 32'h100,      1'b1, 32'h100,      1'b1, 32'h100,      1'b0, 32'h100);
    look("ctr3",       32'h40, 1'b1, 32'h100);
    vec("sat_nt",      1'b0, 32'h40,       1'b1, 32'h40,       1'b1, 1'b0, 32'h100,      1'b1, 32'h100,      1'b1, 32'h100,      1'b1, 32'h44);
    look("ctr2",       32'h40, 1'b1, 32'h100);
    // target change, same-cycle lookup still returns the old target
    vec("tgt_chg",     1'b0, 32'h40,       1'b1, 32'h40,       1'b1, 1'b1, 32'h200,      1'b1, 32'h100,      1'b1, 32'h100,      1'b1, 32'h200);
    look("tgt_new",    32'h40, 1'b1, 32'h200);
    // 0x440 shares index 0 with 0x40 but misses on tag
    vec("alias",       1'b0, 32'h440,      1'b1, 32'h440,      1'b0, 1'b0, 32'h0,        1'b1, 32'h200,      1'b0, 32'h444,      1'b1, 32'h444);
    look("alias_keep", 32'h40, 1'b1, 32'h200);
    vec("nb_hit",      1'b0, 32'h40,       1'b1, 32'h40,       1'b0, 1'b0, 32'h0,        1'b0, 32'h200,      1'b1, 32'h200,      1'b0, 32'h44);
    look("nb_killed",  32'h40, 1'b0, 32'h44);
    // ex_valid=0 with a mismatching outcome: no flush, no allocation
    vec("inval",       1'b0, 32'h80,       1'b0, 32'h80,       1'b1, 1'b1, 32'h300,      1'b0, 32'h84,       1'b0, 32'h84,       1'b0, 32'h300);
    look("inval_none", 32'h80, 1'b0, 32'h84);
    vec("alloc_80",    1'b0, 32'h80,       1'b1, 32'h80,       1'b1, 1'b1, 32'h300,      1'b0, 32'h84,       1'b0, 32'h84,       1'b1, 32'h300);
`ifdef BPU_PERF_CNT_EN
    // branches: cold_alloc nt_1 nt_2 tk_1..tk_4 sat_nt tgt_chg alloc_80 = 10
    // flushes:  cold_alloc nt_1 tk_1 tk_2 sat_nt tgt_chg alias alloc_80 = 8
    chk_perf("perf_run", 32'd10, 32'd8);
`endif
    look("alloc_80_v", 32'h80, 1'b1, 32'h300);
    vec("rst_mid",     1'b1, 32'h80,       1'b1, 32'h80,       1'b1, 1'b1, 32'h400,      1'b0, 32'h84,       1'b0, 32'h84,       1'b0, 32'h0);
`ifdef BPU_PERF_CNT_EN
    chk_perf("perf_rst", 32'd0, 32'd0);
`endif
    look("rst_80",     32'h80, 1'b0, 32'h84);
    look("rst_40",     32'h40, 1'b0, 32'h44);
    // PC arithmetic wraps modulo 2^32
    vec("wrap",        1'b0, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0);

    // Let the monitor drain the queue, bounded by a cycle budget.
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Produces the front-end redirect controls consumed by the fetch PC register: `prediction`, `control_pc`, `flush` and `pc_branch`.
- Holds a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Looked up combinationally with the current fetch PC.
- Trained and checked against branch outcomes resolved in the EX/MEM stage; raises `flush` with the corrected PC on a misprediction.

Parameters:
- INDEX_BITS, 4: log2 of BTB entry count (16 entries).
- CTR_INIT, 2'b10: counter value written on allocation (weakly taken).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- if_pc  input  32  current fetch PC (`cpc`) for lookup.
- prediction  output  1  predict taken for `if_pc`; fetch loads `control_pc` next.
- control_pc  output  32  predicted target for `if_pc`.
- ex_valid  input  1  a real (non-bubble) instruction sits in EX/MEM this cycle.
- ex_pc  input  32  PC of that instruction.
- ex_is_branch  input  1  instruction is a branch/jump.
- ex_taken  input  1  resolved direction.
- ex_target  input  32  resolved taken target.
- ex_pred_taken  input  1  `prediction` value that was piped along with the instruction.
- ex_pred_target  input  32  `control_pc` value that was piped along with it.
- flush  output  1  misprediction; fetch must load `pc_branch`.
- pc_branch  output  32  corrected PC.

Behaviour:
- Index and tag:
  - idx = pc[INDEX_BITS+1:2].
  - tag = pc[31:INDEX_BITS+2].
  - Each entry holds valid, tag, target[31:0] and ctr[1:0].
- Lookup (combinational):
  - hit = valid[idx] && tag match.
  - `prediction` = hit && ctr[1].
  - `control_pc` = target when hit, else if_pc+4.
- Misprediction (combinational, `ex_valid` qualified):
  - branch: `flush`=1 if ex_taken != ex_pred_taken, or if ex_taken && ex_pred_target != ex_target.
  - non-branch: `flush`=1 if ex_pred_taken=1 (aliased entry).
  - When `ex_valid`=0, `flush`=0.
- `pc_branch` = ex_target if (ex_is_branch && ex_taken), else ex_pc+4. PC arithmetic is modulo 2^32.
- Update (posedge clk, only when `ex_valid`):
  - Branch, hit: ctr saturating +1 if taken (max 3), -1 if not taken (min 0). If taken, target <= ex_target.
  - Branch, miss, taken: allocate/overwrite the entry with valid=1, tag, target=ex_target, ctr=CTR_INIT.
  - Branch, miss, not taken: no write.
  - Non-branch that hit: clear valid of that entry.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents (read-before-write). The new value is visible the next cycle.
- Stalls are not seen by this block. The pipeline guarantees each instruction is presented with `ex_valid`=1 exactly once, so no double training occurs.
- Reset:
  - All valid bits and counters clear in one cycle; targets and tags are don't-care.
  - While `rst`=1: `prediction`=0, `control_pc`=if_pc+4, `flush`=0, `pc_branch`=0, and no update is performed.
  - Reset mid-operation discards all training.

Optional Feature:
- Macro BPU_PERF_CNT_EN.
- Defined: adds outputs `perf_branches` [31:0] and `perf_mispredicts` [31:0].
  - Both are cleared by `rst`.
  - `perf_branches` increments on each `ex_valid && ex_is_branch`.
  - `perf_mispredicts` increments on each cycle with `flush`=1.
  - Both wrap at 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Cold miss: after reset, if_pc=0x40 -> `prediction`=0, `control_pc`=0x44. Resolve ex_pc=0x40, taken, target 0x100, pred 0 -> `flush`=1, `pc_branch`=0x100. Next cycle lookup 0x40 -> `prediction`=1, `control_pc`=0x100.
- Counter saturation: train 0x40 not-taken twice from ctr=2 -> ctr 1 then 0, `prediction` 0. Three takens -> 1, 2, 3 and stays 3 after a 4th, `prediction`=1.
- Target change: hit with pred target 0x100, resolved taken to 0x200 -> `flush`=1, `pc_branch`=0x200, and the entry target becomes 0x200.
- Alias kill: entry for 0x40 valid; non-branch at ex_pc=0x440 (same idx, different tag) with ex_pred_taken=1 -> `flush`=1, `pc_branch`=0x444. Entry 0x40 is NOT cleared, because 0x440 missed on tag.
- Same-cycle read/write: if_pc=0x40 while updating idx of 0x40 -> outputs reflect old entry that cycle and the new entry the next cycle. `ex_valid`=0 with mismatching ex_* -> `flush`=0, no state change.
- Reset: assert `rst` with `ex_valid`=1 and a mispredict -> `flush`=0, all entries invalid afterward. With BPU_PERF_CNT_EN, counts after 5 branches and 2 mispredicts read 5 and 2, then 0 after `rst`.
